// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//
// Bundles every signal between the memory arbiter, the two caches and main
// memory. clk and rst are not part of the bundle; they stay plain ports on
// the arbiter.
//
// Modports
//   master : the arbiter's view. It receives cache requests and memory
//            responses, and it drives beat and done pulses and the memory
//            request.
//   slave  : the environment's view (instruction cache, data cache and main
//            memory together). It is the mirror image of master.
//
// Signal groups
//   instruction cache : i_req, i_addr, i_length, i_beat_valid, i_done
//   data cache        : d_req, d_we, d_addr, d_length, d_written_data,
//                       d_data_type, d_beat_valid, d_done
//   shared            : beat_index, rdata, busy
//   main memory       : mem_vis_signal, mem_vis_addr, mem_written_data,
//                       mem_data_type, mem_data, mem_status
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int ENTRY_INDEX_SIZE = 3
);

  // Instruction cache port
  logic                        i_req;
  logic [ADDR_WIDTH-1:0]       i_addr;
  logic [ENTRY_INDEX_SIZE:0]   i_length;
  logic                        i_beat_valid;
  logic                        i_done;

  // Data cache port
  logic                        d_req;
  logic                        d_we;
  logic [ADDR_WIDTH-1:0]       d_addr;
  logic [ENTRY_INDEX_SIZE:0]   d_length;
  logic [LEN-1:0]              d_written_data;
  logic [2:0]                  d_data_type;
  logic                        d_beat_valid;
  logic                        d_done;

  // Shared return path and status
  logic [ENTRY_INDEX_SIZE-1:0] beat_index;
  logic [LEN-1:0]              rdata;
  logic                        busy;

  // Main memory port
  logic [1:0]                  mem_vis_signal;
  logic [ADDR_WIDTH-1:0]       mem_vis_addr;
  logic [LEN-1:0]              mem_written_data;
  logic [2:0]                  mem_data_type;
  logic [LEN-1:0]              mem_data;
  logic [1:0]                  mem_status;

  modport master (
    input  i_req, i_addr, i_length,
    input  d_req, d_we, d_addr, d_length, d_written_data, d_data_type,
    input  mem_data, mem_status,
    output i_beat_valid, i_done, d_beat_valid, d_done,
    output beat_index, rdata, busy,
    output mem_vis_signal, mem_vis_addr, mem_written_data, mem_data_type
  );

  modport slave (
    output i_req, i_addr, i_length,
    output d_req, d_we, d_addr, d_length, d_written_data, d_data_type,
    output mem_data, mem_status,
    input  i_beat_valid, i_done, d_beat_valid, d_done,
    input  beat_index, rdata, busy,
    input  mem_vis_signal, mem_vis_addr, mem_written_data, mem_data_type
  );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// This is the single-master controller between the instruction cache, the
// data cache and the 4-byte-wide main memory. When both caches request at
// once it picks one. It then runs a line transfer of up to
// 2**ENTRY_INDEX_SIZE words as a chain of single-word memory accesses:
//
//   IDLE -> (REQ -> WAIT)* -> DONE -> IDLE
//
// REQ presents one memory command for exactly one cycle. WAIT drives NOP
// until memory reports a FINISHED code. DONE is a one-cycle gap that gives
// the served cache time to drop its request.
//
// Ports
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset; abandons any in-flight access
//   bus : mem_arbiter_if.master (cache request/return ports, memory port)
//
// Encodings
//   mem_vis_signal : MEM_NOP=0, MEM_READ=1, MEM_WRITE=2
//   mem_status     : MEM_RESTING=0, MEM_INST_FINISHED=1, MEM_DATA_FINISHED=2
//   data type      : ONE_BYTE=1, TWO_BYTE=2, FOUR_BYTE=4
//
// Configuration macro
//   MEM_ARB_ROUND_ROBIN_EN : when defined, a tie in IDLE goes to the port
//                            that did not win the previous access. When
//                            undefined, the data cache always wins ties.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  localparam int CNT_W = ENTRY_INDEX_SIZE + 1;

  localparam logic [1:0] MEM_NOP           = 2'd0;
  localparam logic [1:0] MEM_READ          = 2'd1;
  localparam logic [1:0] MEM_WRITE         = 2'd2;
  localparam logic [1:0] MEM_RESTING       = 2'd0;
  localparam logic [2:0] FOUR_BYTE         = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // ---------------------------------------------------------------------------
  // State registers and their next-state values
  // ---------------------------------------------------------------------------
  state_t                      state, state_n;
  owner_t                      owner, owner_n;
  logic                        we, we_n;
  logic [ADDR_WIDTH-1:0]       addr, addr_n;
  logic [CNT_W-1:0]            beats_left, beats_left_n;
  logic [ENTRY_INDEX_SIZE-1:0] beat_idx, beat_idx_n;
  logic [LEN-1:0]              rdata_q, rdata_n;
  logic                        i_bv_q, i_bv_n;
  logic                        d_bv_q, d_bv_n;
  logic                        i_dn_q, i_dn_n;
  logic                        d_dn_q, d_dn_n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t                      last_grant, last_grant_n;
`endif

  // Grant decision. It is only acted on in IDLE.
  logic                        grant_d;
  logic [CNT_W-1:0]            req_len;
  // A write beat that is the only beat of its access keeps the cache's width.
  // Every other write beat is a full word.
  logic                        single_beat;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie, serve the port that did not win last time.
  assign grant_d = bus.d_req && (!bus.i_req || (last_grant == OWN_I));
`else
  // Data requests always win ties.
  assign grant_d = bus.d_req;
`endif

  assign req_len     = grant_d ? bus.d_length : bus.i_length;
  assign single_beat = (beat_idx == '0) && (beats_left == CNT_W'(1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_I;
      we         <= 1'b0;
      addr       <= '0;
      beats_left <= '0;
      beat_idx   <= '0;
      rdata_q    <= '0;
      i_bv_q     <= 1'b0;
      d_bv_q     <= 1'b0;
      i_dn_q     <= 1'b0;
      d_dn_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant <= OWN_I;
`endif
    end else begin
      // NOTE: non-blocking assignments, so every register here updates from
      // values sampled before the edge, whatever order the lines appear in.
      state      <= state_n;
      owner      <= owner_n;
      we         <= we_n;
      addr       <= addr_n;
      beats_left <= beats_left_n;
      beat_idx   <= beat_idx_n;
      rdata_q    <= rdata_n;
      i_bv_q     <= i_bv_n;
      d_bv_q     <= d_bv_n;
      i_dn_q     <= i_dn_n;
      d_dn_q     <= d_dn_n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant <= last_grant_n;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and memory-side outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a
    // latch.
    state_n      = state;
    owner_n      = owner;
    we_n         = we;
    addr_n       = addr;
    beats_left_n = beats_left;
    beat_idx_n   = beat_idx;
    rdata_n      = rdata_q;
    i_bv_n       = 1'b0;
    d_bv_n       = 1'b0;
    i_dn_n       = 1'b0;
    d_dn_n       = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_n = last_grant;
`endif

    bus.mem_vis_signal   = MEM_NOP;
    bus.mem_vis_addr     = '0;
    bus.mem_written_data = '0;
    bus.mem_data_type    = '0;

    unique case (state)
      S_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          owner_n      = grant_d ? OWN_D : OWN_I;
          // The instruction port only reads, so its accesses never write.
          we_n         = grant_d && bus.d_we;
          addr_n       = grant_d ? bus.d_addr : bus.i_addr;
          // A zero length still moves one word.
          beats_left_n = (req_len == '0) ? CNT_W'(1) : req_len;
          beat_idx_n   = '0;
          state_n      = S_REQ;
        end
      end

      S_REQ: begin
        // Each command is held for one cycle only. The NOP in WAIT that
        // follows lets memory return to RESTING before the next command.
        bus.mem_vis_addr = addr;
        if ((owner == OWN_D) && we) begin
          bus.mem_vis_signal   = MEM_WRITE;
          bus.mem_written_data = bus.d_written_data;
          bus.mem_data_type    = single_beat ? bus.d_data_type : FOUR_BYTE;
        end else begin
          bus.mem_vis_signal   = MEM_READ;
        end
        state_n = S_WAIT;
      end

      S_WAIT: begin
        // Both FINISHED codes complete the beat. RESTING means a slow memory
        // is still busy, so the controller keeps waiting.
        if (bus.mem_status != MEM_RESTING) begin
          if (!we) begin
            rdata_n = bus.mem_data;
            i_bv_n  = (owner == OWN_I);
            d_bv_n  = (owner == OWN_D);
          end
          if (beats_left <= CNT_W'(1)) begin
            i_dn_n  = (owner == OWN_I);
            d_dn_n  = (owner == OWN_D);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_n = owner;
`endif
            state_n = S_DONE;
          end else begin
            // The byte address wraps at the top of the address space.
            addr_n       = addr + ADDR_WIDTH'(4);
            beat_idx_n   = beat_idx + ENTRY_INDEX_SIZE'(1);
            beats_left_n = beats_left - CNT_W'(1);
            state_n      = S_REQ;
          end
        end
      end

      S_DONE: begin
        // Requests are ignored here while the served cache drops its request.
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered cache-side outputs
  // ---------------------------------------------------------------------------
  assign bus.beat_index   = beat_idx;
  assign bus.rdata        = rdata_q;
  assign bus.i_beat_valid = i_bv_q;
  assign bus.d_beat_valid = d_bv_q;
  assign bus.i_done       = i_dn_q;
  assign bus.d_done       = d_dn_q;
  assign bus.busy         = (state != S_IDLE);

endmodule : mem_arbiter
